// File: rtl/icache_refill_responder.sv
// Instruction-cache refill responder: accepts one line request at a time, fetches the
// line as BEATS pipelined word reads and returns it to the cache in one r_valid pulse.
module icache_refill_responder #(
  parameter int FETCH_ADDR_WIDTH  = 32,
  parameter int REFILL_DATA_WIDTH = 128,
  parameter int MEM_DATA_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         refill_req_i,
  output logic                         refill_gnt_o,
  input  logic [FETCH_ADDR_WIDTH-1:0]  refill_addr_i,
  output logic                         refill_r_valid_o,
  output logic [REFILL_DATA_WIDTH-1:0] refill_r_data_o,
  output logic                         mem_req_o,
  input  logic                         mem_gnt_i,
  output logic [FETCH_ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                         mem_r_valid_i,
  input  logic [MEM_DATA_WIDTH-1:0]    mem_r_data_i
);

  localparam int BEATS      = REFILL_DATA_WIDTH / MEM_DATA_WIDTH;
  localparam int LANE_BITS  = $clog2(BEATS);
  localparam int CNT_W      = LANE_BITS + 1;
  localparam int LINE_OFF   = $clog2(REFILL_DATA_WIDTH / 8);
  localparam int BEAT_SHIFT = $clog2(MEM_DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                       state_r;
  logic [FETCH_ADDR_WIDTH-1:0]  line_addr_r;
  logic [CNT_W-1:0]             issue_cnt_r;
  logic [CNT_W-1:0]             rx_cnt_r;
  logic [REFILL_DATA_WIDTH-1:0] line_r;
  logic                         mem_req_r;
  logic                         r_valid_r;

  logic                         rx_en_s;
  logic                         last_rx_s;
  logic                         last_issue_s;
  logic [LANE_BITS-1:0]         lane_s;
  logic [FETCH_ADDR_WIDTH-1:0]  beat_off_s;

  // Beats are only accepted while a line is in flight; IDLE/RESP responses are stale.
  assign rx_en_s      = mem_r_valid_i & ((state_r == ISSUE) | (state_r == DRAIN));
  assign last_rx_s    = rx_en_s & (rx_cnt_r == LAST_BEAT);
  assign last_issue_s = (state_r == ISSUE) & mem_gnt_i & (issue_cnt_r == LAST_BEAT);
  assign lane_s       = rx_cnt_r[LANE_BITS-1:0];
  assign beat_off_s   = FETCH_ADDR_WIDTH'(issue_cnt_r) << BEAT_SHIFT;

  assign refill_gnt_o     = (state_r == IDLE) & refill_req_i;
  assign refill_r_valid_o = r_valid_r;
  assign refill_r_data_o  = line_r;
  assign mem_req_o        = mem_req_r;
  assign mem_addr_o       = line_addr_r + beat_off_s;

  // Refill sequencer: request capture, beat issue/receive counting and response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      line_addr_r <= '0;
      issue_cnt_r <= '0;
      rx_cnt_r    <= '0;
      mem_req_r   <= 1'b0;
      r_valid_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (refill_req_i) begin
            state_r     <= ISSUE;
            line_addr_r <= {refill_addr_i[FETCH_ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
            issue_cnt_r <= '0;
            rx_cnt_r    <= '0;
            mem_req_r   <= 1'b1;
          end
        end
        ISSUE: begin
          if (mem_gnt_i) begin
            issue_cnt_r <= issue_cnt_r + CNT_W'(1);
          end
          if (rx_en_s) begin
            rx_cnt_r <= rx_cnt_r + CNT_W'(1);
          end
          if (last_issue_s) begin
            mem_req_r <= 1'b0;
            if (last_rx_s) begin
              state_r   <= RESP;
              r_valid_r <= 1'b1;
            end else begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rx_en_s) begin
            rx_cnt_r <= rx_cnt_r + CNT_W'(1);
          end
          if (last_rx_s) begin
            state_r   <= RESP;
            r_valid_r <= 1'b1;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          r_valid_r <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          r_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Line buffer: lane rx_cnt takes the next returning beat, lowest address in the LSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_r <= '0;
    end else if (rx_en_s) begin
      line_r[lane_s*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_r_data_i;
    end else begin
      line_r <= line_r;
    end
  end

endmodule

// File: tb/tb_icache_refill_responder.sv
// Randomised bench for icache_refill_responder: a transaction-level model of the refill
// (counts of beats issued/received, expected line) is compared against the DUT every cycle.
module tb_icache_refill_responder;

  localparam int FAW   = 32;
  localparam int RDW   = 128;
  localparam int MDW   = 32;
  localparam int BEATS = RDW / MDW;
  localparam logic [RDW-1:0] DIR_LINE = 128'h44444444_33333333_22222222_11111111;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           refill_req_i = 1'b0;
  logic           refill_gnt_o;
  logic [FAW-1:0] refill_addr_i = '0;
  logic           refill_r_valid_o;
  logic [RDW-1:0] refill_r_data_o;
  logic           mem_req_o;
  logic           mem_gnt_i = 1'b0;
  logic [FAW-1:0] mem_addr_o;
  logic           mem_r_valid_i = 1'b0;
  logic [MDW-1:0] mem_r_data_i = '0;

  icache_refill_responder #(
    .FETCH_ADDR_WIDTH (FAW),
    .REFILL_DATA_WIDTH(RDW),
    .MEM_DATA_WIDTH   (MDW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .refill_req_i    (refill_req_i),
    .refill_gnt_o    (refill_gnt_o),
    .refill_addr_i   (refill_addr_i),
    .refill_r_valid_o(refill_r_valid_o),
    .refill_r_data_o (refill_r_data_o),
    .mem_req_o       (mem_req_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_addr_o      (mem_addr_o),
    .mem_r_valid_i   (mem_r_valid_i),
    .mem_r_data_i    (mem_r_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Abstract refill model: busy while a line is outstanding, resp for the pulse cycle.
  bit             m_busy = 1'b0;
  bit             m_resp = 1'b0;
  int             m_issued = 0;
  int             m_rx = 0;
  logic [FAW-1:0] m_base = '0;
  logic [RDW-1:0] m_buf = '0;
  int             grant_cnt = 0;
  int             resp_count = 0;
  int             grant_cyc = 0;
  int             resp_cyc = 0;
  logic [FAW-1:0] issued_log[$];

  typedef struct {
    logic [FAW-1:0] addr;
    logic [MDW-1:0] data;
    int             due;
  } beat_t;
  beat_t pend[$];

  int gnt_mode = 0;
  int lat_min = 1;
  int lat_max = 1;
  int stall_cnt = 0;
  bit spurious = 1'b0;
  bit directed_data = 1'b1;

  task automatic check(string name, logic [RDW-1:0] act, logic [RDW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [MDW-1:0] beat_data(logic [FAW-1:0] a);
    logic [MDW-1:0] k;
    k = MDW'((a >> 2) & 32'd3) + 32'd1;
    return directed_data ? (32'h11111111 * k) : MDW'($urandom);
  endfunction

  task automatic step();
    logic           mg, rv, from_mem, req, exp_req;
    logic [MDW-1:0] rd;
    logic [FAW-1:0] addr, exp_addr;
    @(negedge clk);
    exp_req = m_busy && (m_issued < BEATS);
    case (gnt_mode)
      0:       mg = 1'b1;
      1:       mg = 1'($urandom_range(0, 1));
      default: mg = !(exp_req && m_issued == 2 && stall_cnt < 3);
    endcase
    from_mem = (pend.size() > 0) && (pend[0].due <= cyc);
    rv = from_mem || spurious;
    rd = from_mem ? pend[0].data : (spurious ? 32'hDEADBEEF : MDW'($urandom));
    mem_gnt_i = mg;
    mem_r_valid_i = rv;
    mem_r_data_i = rd;
    #1;
    req = refill_req_i;
    addr = refill_addr_i;
    exp_addr = m_base + FAW'(m_issued) * 32'd4;
    check("refill_gnt", refill_gnt_o, !m_busy && !m_resp && req);
    check("mem_req", mem_req_o, exp_req);
    if (exp_req) check("mem_addr", mem_addr_o, exp_addr);
    check("r_valid", refill_r_valid_o, m_resp);
    check("r_data", refill_r_data_o, m_buf);
    @(posedge clk);
    if (from_mem) void'(pend.pop_front());
    if (gnt_mode == 2 && exp_req && m_issued == 2 && !mg) stall_cnt++;
    if (m_resp) begin
      m_resp = 1'b0;
    end else if (!m_busy) begin
      if (req) begin
        m_busy = 1'b1;
        m_base = {addr[FAW-1:4], 4'h0};
        m_issued = 0;
        m_rx = 0;
        grant_cyc = cyc;
        grant_cnt++;
      end
    end else begin
      if (exp_req && mg) begin
        pend.push_back('{exp_addr, beat_data(exp_addr), cyc + $urandom_range(lat_min, lat_max)});
        issued_log.push_back(exp_addr);
        m_issued++;
      end
      if (rv) begin
        m_buf[m_rx*MDW +: MDW] = rd;
        m_rx++;
        if (m_rx == BEATS) begin
          m_busy = 1'b0;
          m_resp = 1'b1;
          resp_cyc = cyc + 1;
          resp_count++;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic refill_start(logic [FAW-1:0] a, bit hold);
    int g0, n;
    g0 = grant_cnt;
    n = 0;
    issued_log.delete();
    refill_req_i = 1'b1;
    refill_addr_i = a;
    while (grant_cnt == g0 && n < 60) begin
      step();
      n++;
    end
    if (grant_cnt == g0) check("grant_timeout", 1'b0, 1'b1);
    if (!hold) refill_req_i = 1'b0;
  endtask

  task automatic refill_finish();
    int r0, n;
    r0 = resp_count;
    n = 0;
    while (resp_count == r0 && n < 200) begin
      step();
      n++;
    end
    if (resp_count == r0) check("resp_timeout", 1'b0, 1'b1);
    step();
  endtask

  initial begin
    int first_resp;
    #1;
    check("rst_gnt", refill_gnt_o, 1'b0);
    check("rst_r_valid", refill_r_valid_o, 1'b0);
    check("rst_r_data", refill_r_data_o, '0);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Single refill, always-grant memory, one-cycle data latency.
    refill_start(32'h1C00_0034, 1'b0);
    refill_finish();
    check("t1_lat", 32'(resp_cyc - grant_cyc), 32'd6);
    check("t1_a0", issued_log[0], 32'h1C00_0030);
    check("t1_a1", issued_log[1], 32'h1C00_0034);
    check("t1_a2", issued_log[2], 32'h1C00_0038);
    check("t1_a3", issued_log[3], 32'h1C00_003C);
    check("t1_line", refill_r_data_o, DIR_LINE);

    // Stalled grant on beat 2 with long data latency; request held while busy.
    gnt_mode = 2; stall_cnt = 0; lat_min = 4; lat_max = 4;
    refill_start(32'h1C00_0034, 1'b1);
    refill_finish();
    refill_req_i = 1'b0;
    check("t2_stalls", 32'(stall_cnt), 32'd3);
    check("t2_a2", issued_log[2], 32'h1C00_0038);
    check("t2_line", refill_r_data_o, DIR_LINE);

    // Back-to-back: request held across RESP, second line from 0x0FF0.
    gnt_mode = 0; lat_min = 1; lat_max = 2;
    refill_start(32'h1C00_0104, 1'b1);
    refill_addr_i = 32'h0000_0FF0;
    refill_finish();
    first_resp = resp_cyc;
    refill_start(32'h0000_0FF0, 1'b0);
    check("t3_b2b_gnt", 32'(grant_cyc), 32'(first_resp + 1));
    check("t3_hold_line", refill_r_data_o, DIR_LINE);
    refill_finish();
    check("t3_a0", issued_log[0], 32'h0000_0FF0);

    // Spurious memory response while idle must not touch the line or the counters.
    spurious = 1'b1;
    repeat (3) step();
    spurious = 1'b0;
    check("t4_line", refill_r_data_o, DIR_LINE);

    // Address wrap at the top of the address space.
    refill_start(32'hFFFF_FFF8, 1'b0);
    refill_finish();
    check("t5_a0", issued_log[0], 32'hFFFF_FFF0);
    check("t5_a3", issued_log[3], 32'hFFFF_FFFC);
    check("t5_line", refill_r_data_o, DIR_LINE);

    // Reset in DRAIN with two beats still outstanding.
    directed_data = 1'b0; lat_min = 4; lat_max = 4;
    refill_start(32'h2000_0040, 1'b0);
    begin
      int n = 0;
      while (!(m_busy && m_issued == BEATS && m_rx == 2) && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) check("t6_drain_timeout", 1'b0, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    mem_r_valid_i = 1'b0;
    #1;
    check("t6_gnt", refill_gnt_o, 1'b0);
    check("t6_r_valid", refill_r_valid_o, 1'b0);
    check("t6_r_data", refill_r_data_o, '0);
    check("t6_mem_req", mem_req_o, 1'b0);
    check("t6_mem_addr", mem_addr_o, '0);
    m_busy = 1'b0; m_resp = 1'b0; m_issued = 0; m_rx = 0; m_base = '0; m_buf = '0;
    @(posedge clk);
    cyc++;
    #2;
    rst_n = 1'b1;
    repeat (4) step();
    check("t6_dropped", refill_r_data_o, '0);
    directed_data = 1'b1; lat_min = 1; lat_max = 1;
    refill_start(32'h2000_0040, 1'b0);
    refill_finish();
    check("t6_line", refill_r_data_o, DIR_LINE);

    // Random traffic: random grants, latencies, addresses and idle gaps.
    directed_data = 1'b0; gnt_mode = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 25; i++) begin
      refill_start(FAW'($urandom), 1'($urandom_range(0, 1)));
      refill_finish();
      if ($urandom_range(0, 2) == 0) begin
        refill_req_i = 1'b0;
        spurious = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) step();
        spurious = 1'b0;
      end
    end
    refill_req_i = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_responder.md
# icache_refill_responder

Memory-side responder for the instruction-cache refill port. It accepts one line-refill request at a time on the req/gnt/addr channel and answers with a single-cycle r_valid pulse carrying a full REFILL_DATA_WIDTH line. It sits between the refill arbiter output and a narrower word-wide L2/TCDM port, and builds each line from REFILL_DATA_WIDTH/MEM_DATA_WIDTH pipelined memory beats.

## Interface
- FETCH_ADDR_WIDTH, 32, byte address width on both sides.
- REFILL_DATA_WIDTH, 128, line width returned to the cache.
- MEM_DATA_WIDTH, 32, memory beat width. REFILL_DATA_WIDTH/MEM_DATA_WIDTH (BEATS) must be a power of two, ≥2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- refill_req_i  in  1  line request from initiator.
- refill_gnt_o  out  1  request accepted (combinational).
- refill_addr_i  in  FETCH_ADDR_WIDTH  requested address; line offset bits ignored.
- refill_r_valid_o  out  1  line response valid, one-cycle pulse.
- refill_r_data_o  out  REFILL_DATA_WIDTH  assembled line.
- mem_req_o  out  1  beat request.
- mem_gnt_i  in  1  beat accepted.
- mem_addr_o  out  FETCH_ADDR_WIDTH  beat byte address.
- mem_r_valid_i  in  1  beat read data valid (in order, ≥1 cycle after gnt).
- mem_r_data_i  in  MEM_DATA_WIDTH  beat read data.

## Operation
- States: IDLE, ISSUE, DRAIN, RESP. Registers: line_addr, issue_cnt, rx_cnt (log2(BEATS)+1 bits each), line buffer.
- IDLE: refill_gnt_o = refill_req_i. On req&gnt: line_addr <= refill_addr_i with low log2(REFILL_DATA_WIDTH/8) bits cleared; issue_cnt, rx_cnt <= 0; → ISSUE.
- ISSUE: mem_req_o = 1; mem_addr_o = line_addr + issue_cnt·(MEM_DATA_WIDTH/8). On mem_gnt_i, issue_cnt++. When the beat with issue_cnt = BEATS−1 is granted → DRAIN (or straight to RESP if that also completes rx_cnt).
- Any state ISSUE/DRAIN: on mem_r_valid_i, write mem_r_data_i into lane rx_cnt (bits [rx_cnt·MEM_DATA_WIDTH +: MEM_DATA_WIDTH]), rx_cnt++. Lowest address in LSBs.
- DRAIN: mem_req_o = 0. When the beat with rx_cnt = BEATS−1 arrives → RESP.
- RESP: refill_r_valid_o = 1 for exactly one cycle; → IDLE. refill_gnt_o = 0 here.
- refill_gnt_o is 0 in ISSUE/DRAIN/RESP; requests held high while busy wait.
- refill_r_data_o is the line buffer; it holds the last line until lanes are overwritten by the next refill.
- mem_r_valid_i in IDLE or RESP is ignored (no write, no counter change).
- mem_addr_o outside ISSUE is line_addr + issue_cnt (don't-care, but deterministic).
- Address addition wraps modulo 2^FETCH_ADDR_WIDTH; it cannot cross a line because line_addr is aligned.

## Timing
- Reset: state IDLE, counters 0, line_addr 0, buffer 0; so refill_gnt_o 0 (while refill_req_i=0), refill_r_valid_o 0, refill_r_data_o 0, mem_req_o 0, mem_addr_o 0.
- Reset mid-transaction aborts: no r_valid is produced; late memory beats arrive in IDLE and are dropped.
- Best case (mem_gnt_i=1 always, r_valid 1 cycle after gnt, BEATS=4): gnt in cycle 0, beats granted cycles 1–4, data cycles 2–5, refill_r_valid_o in cycle 6. Latency = BEATS+2 cycles from grant.
- Earliest new grant is the cycle after RESP. Accepted-to-accepted throughput is one line per BEATS+3 cycles.
- mem_gnt_i stalls hold mem_addr_o and mem_req_o stable. Response gaps simply extend DRAIN.
- A beat grant and a beat response can occur in the same cycle. Both counters advance independently.

## Test plan
- Single refill, addr 0x1C00_0034, mem always grants, 1-cycle data latency, beats 0x11111111..0x44444444: required mem_addr 0x1C00_0030/34/38/3C; r_valid at grant+6; r_data = 0x44444444_33333333_22222222_11111111.
- Stalled memory: mem_gnt_i low for 3 cycles on beat 2 and data latency 4: mem_addr_o held at …38 during the stall; exactly one r_valid; data correct; refill_gnt_o stays 0 throughout.
- Back-to-back requests (req held high across RESP, second addr 0x0000_0FF0): second grant comes the cycle after r_valid. The second line is issued from 0x0FF0, and the first r_data remains stable until overwritten.
- Spurious mem_r_valid_i = 1, data 0xDEADBEEF, in IDLE: no r_valid, buffer unchanged, rx_cnt 0.
- Reset asserted during DRAIN with 2 beats outstanding: outputs return to reset values immediately. The outstanding beats are ignored. A new refill completes with correct data.
- Address wrap: addr 0xFFFF_FFF8 gives beats 0xFFFF_FFF0/F4/F8/FC and a correct line.
